// File: rtl/acc_rr_scheduler_pkg.sv
// rtl/acc_rr_scheduler_pkg.sv - shared types and arbitration helpers for acc_rr_scheduler
//
// Purpose: FSM state encoding, one-hot decode and round-robin pick used by the
// scheduler top. Helpers work on a MAX_REQ-wide vector; callers zero-extend.
package acc_rr_scheduler_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } sched_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int sel);
        logic [MAX_REQ-1:0] v;
        v = {{(MAX_REQ-1){1'b0}}, 1'b1} << sel;
        return v;
    endfunction

    function automatic int lowest_set(input logic [MAX_REQ-1:0] v);
        int r;
        r = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    // Requests at or above ptr take priority; if none, wrap to the lowest set bit.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr);
        logic [MAX_REQ-1:0] mask;
        logic [MAX_REQ-1:0] masked;
        mask   = {MAX_REQ{1'b1}} << ptr;
        masked = req & mask;
        return (masked != '0) ? lowest_set(masked) : lowest_set(req);
    endfunction

endpackage

// File: rtl/acc_rr_scheduler_acc.sv
// rtl/acc_rr_scheduler_acc.sv - serial saturating fixed-point accumulator
//
// Purpose: on VALID_IN, sums NUM_INPUTS operands (plus EXT_VALUE_IN when
// HAS_EXT_BIAS) one per cycle, saturating at the WIDTH-bit two's complement
// range with a sticky OVERFLOW. Operands share FRAC_BITS so no alignment is needed.
// Ports:
//   CLK, RSTN     clock, synchronous active-low reset
//   VALID_IN      start pulse; restarts any operation in progress
//   VALUES_IN     operand vector, operand i at slice i (sampled serially)
//   EXT_VALUE_IN  bias operand, added last when HAS_EXT_BIAS
//   VALID_OUT     one-cycle pulse when VALUE_OUT/OVERFLOW are final
//   VALUE_OUT     accumulated value
//   OVERFLOW      sticky saturation flag of this operation
module acc_rr_scheduler_acc #(
    parameter int WIDTH        = 8,
    parameter int FRAC_BITS    = 3,
    parameter int NUM_INPUTS   = 16,
    parameter bit HAS_EXT_BIAS = 1'b0
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          VALID_IN,
    input  logic [NUM_INPUTS*WIDTH-1:0]   VALUES_IN,
    input  logic [WIDTH-1:0]              EXT_VALUE_IN,
    output logic                          VALID_OUT,
    output logic [WIDTH-1:0]              VALUE_OUT,
    output logic                          OVERFLOW
);

    localparam int NUM_OPS = NUM_INPUTS + (HAS_EXT_BIAS ? 1 : 0);
    localparam int IDX_W   = $clog2(NUM_OPS + 1);

    if (FRAC_BITS >= WIDTH) begin : g_bad_frac_bits
        $error("FRAC_BITS must be less than WIDTH");
    end

    logic             busy_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic             valid_q;

    logic [WIDTH-1:0] op;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] sum_sat;

    always_comb begin
        op = EXT_VALUE_IN;
        if (int'(idx_q) < NUM_INPUTS) begin
            op = VALUES_IN[int'(idx_q)*WIDTH +: WIDTH];
        end
        sum     = {acc_q[WIDTH-1], acc_q} + {op[WIDTH-1], op};
        sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        sum_sat = sum[WIDTH-1:0];
        if (sum_ovf) begin
            sum_sat = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (VALID_IN) begin
                busy_q <= 1'b1;
                idx_q  <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else if (busy_q) begin
                acc_q <= sum_sat;
                ovf_q <= ovf_q | sum_ovf;
                if (idx_q == IDX_W'(NUM_OPS - 1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign VALID_OUT = valid_q;
    assign VALUE_OUT = acc_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: rtl/acc_rr_scheduler.sv
// rtl/acc_rr_scheduler.sv - round-robin scheduler sharing one accumulator between requesters
//
// Purpose: arbitrates REQ_IN round-robin, muxes the winner's operands into the
// accumulator, waits for its result under a watchdog and reports back.
// Ports:
//   CLK, RSTN      clock, synchronous active-low reset (also resets accumulator)
//   REQ_IN         per-requester request level
//   REQ_VALUES_IN  operand vectors, requester i at slice i
//   REQ_BIAS_IN    bias per requester (used only when HAS_EXT_BIAS)
//   GRANT_OUT      one-hot grant, zero when idle
//   DONE_OUT       one-cycle success pulse to the granted requester
//   ERROR_OUT      one-cycle pulse on watchdog expiry
//   RESULT_OUT     last captured result, held
//   OVERFLOW_OUT   overflow of last captured result, held
//   BUSY_OUT       high whenever not idle
module acc_rr_scheduler
    import acc_rr_scheduler_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FRAC_BITS    = 3,
    parameter int NUM_INPUTS   = 16,
    parameter bit HAS_EXT_BIAS = 1'b0,
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic [NUM_REQ-1:0]                  REQ_IN,
    input  logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0] REQ_VALUES_IN,
    input  logic [NUM_REQ*WIDTH-1:0]            REQ_BIAS_IN,
    output logic [NUM_REQ-1:0]                  GRANT_OUT,
    output logic [NUM_REQ-1:0]                  DONE_OUT,
    output logic                                ERROR_OUT,
    output logic [WIDTH-1:0]                    RESULT_OUT,
    output logic                                OVERFLOW_OUT,
    output logic                                BUSY_OUT
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int VEC_W = NUM_INPUTS * WIDTH;

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic               acc_valid_in;
    logic [VEC_W-1:0]   acc_values;
    logic [WIDTH-1:0]   acc_bias;
    logic               acc_valid_out;
    logic [WIDTH-1:0]   acc_value;
    logic               acc_ovf;
    logic [NUM_REQ-1:0] sel_onehot;

    assign sel_onehot = NUM_REQ'(onehot(int'(sel_q)));

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        ok_d         = ok_q;
        wd_d         = wd_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        acc_valid_in = 1'b0;
        DONE_OUT     = '0;
        ERROR_OUT    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|REQ_IN) begin
                    sel_d   = SEL_W'(rr_pick(MAX_REQ'(REQ_IN), int'(ptr_q)));
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                acc_valid_in = 1'b1;
                wd_d         = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts as success.
                if (acc_valid_out) begin
                    result_d = acc_value;
                    ovf_d    = acc_ovf;
                    ok_d     = 1'b1;
                    state_d  = ST_FINISH;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    ok_d    = 1'b0;
                    state_d = ST_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_FINISH: begin
                if (ok_q) begin
                    DONE_OUT = sel_onehot;
                end else begin
                    ERROR_OUT = 1'b1;
                end
                ptr_d   = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            ok_q     <= 1'b0;
            wd_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            ok_q     <= ok_d;
            wd_q     <= wd_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Operands stay routed for the whole operation since the accumulator reads them serially.
    always_comb begin
        acc_values = '0;
        acc_bias   = '0;
        if (state_q != ST_IDLE) begin
            acc_values = REQ_VALUES_IN[int'(sel_q)*VEC_W +: VEC_W];
            acc_bias   = REQ_BIAS_IN[int'(sel_q)*WIDTH +: WIDTH];
        end
    end

    acc_rr_scheduler_acc #(
        .WIDTH        (WIDTH),
        .FRAC_BITS    (FRAC_BITS),
        .NUM_INPUTS   (NUM_INPUTS),
        .HAS_EXT_BIAS (HAS_EXT_BIAS)
    ) u_acc (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .VALID_IN     (acc_valid_in),
        .VALUES_IN    (acc_values),
        .EXT_VALUE_IN (acc_bias),
        .VALID_OUT    (acc_valid_out),
        .VALUE_OUT    (acc_value),
        .OVERFLOW     (acc_ovf)
    );

    assign GRANT_OUT    = (state_q != ST_IDLE) ? sel_onehot : '0;
    assign BUSY_OUT     = (state_q != ST_IDLE);
    assign RESULT_OUT   = result_q;
    assign OVERFLOW_OUT = ovf_q;

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// tb/tb_acc_rr_scheduler.sv - scoreboard bench for acc_rr_scheduler
module tb_acc_rr_scheduler;

    typedef struct {
        logic       err;
        logic [3:0] done;
        logic [3:0] grant;
        logic [7:0] result;
        logic       chk_res;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rstn;
    int          cyc;
    int          vectors;
    int          miscompares;

    logic [3:0]   req_a, req_b;
    logic [127:0] vals_a, vals_b;
    logic [31:0]  bias_a, bias_b;
    logic [3:0]   grant_a, done_a, grant_b, done_b;
    logic         err_a, ovf_a, busy_a, err_b, ovf_b, busy_b;
    logic [7:0]   res_a, res_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    acc_rr_scheduler #(
        .WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(4), .HAS_EXT_BIAS(1'b1), .NUM_REQ(4), .TIMEOUT(64)
    ) dut_a (
        .CLK(clk), .RSTN(rstn), .REQ_IN(req_a), .REQ_VALUES_IN(vals_a), .REQ_BIAS_IN(bias_a),
        .GRANT_OUT(grant_a), .DONE_OUT(done_a), .ERROR_OUT(err_a), .RESULT_OUT(res_a),
        .OVERFLOW_OUT(ovf_a), .BUSY_OUT(busy_a)
    );

    acc_rr_scheduler #(
        .WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(4), .HAS_EXT_BIAS(1'b0), .NUM_REQ(4), .TIMEOUT(3)
    ) dut_b (
        .CLK(clk), .RSTN(rstn), .REQ_IN(req_b), .REQ_VALUES_IN(vals_b), .REQ_BIAS_IN(bias_b),
        .GRANT_OUT(grant_b), .DONE_OUT(done_b), .ERROR_OUT(err_b), .RESULT_OUT(res_b),
        .OVERFLOW_OUT(ovf_b), .BUSY_OUT(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done_a != 4'b0 || err_a) begin
            if (exp_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event_a: done %0h error %0b with nothing expected (cycle %0d)",
                         done_a, err_a, cyc);
            end else begin
                ea = exp_a.pop_front();
                check("a_error", 32'(err_a), 32'(ea.err));
                check("a_done", 32'(done_a), 32'(ea.done));
                check("a_grant_at_done", 32'(grant_a), 32'(ea.grant));
                if (ea.chk_res) check("a_result", 32'(res_a), 32'(ea.result));
                check("a_overflow", 32'(ovf_a), 32'(ea.ovf));
                check("a_event_cycle", 32'(cyc), 32'(ea.cyc));
            end
        end
        if (done_b != 4'b0 || err_b) begin
            if (exp_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event_b: done %0h error %0b with nothing expected (cycle %0d)",
                         done_b, err_b, cyc);
            end else begin
                eb = exp_b.pop_front();
                check("b_error", 32'(err_b), 32'(eb.err));
                check("b_done", 32'(done_b), 32'(eb.done));
                check("b_grant_at_event", 32'(grant_b), 32'(eb.grant));
                check("b_result_held", 32'(res_b), 32'(eb.result));
                check("b_event_cycle", 32'(cyc), 32'(eb.cyc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vals_a(input int r, input logic [7:0] v, input logic [7:0] b);
        for (int i = 0; i < 4; i++) vals_a[(r*4+i)*8 +: 8] = v;
        bias_a[r*8 +: 8] = b;
    endtask

    // Single request on A with REQ dropped right after grant; result lands at t+8.
    task automatic run_a(input logic [3:0] req, input logic [3:0] g, input logic [7:0] r,
                         input logic chk, input logic o);
        int t;
        t = cyc;
        req_a = req;
        exp_a.push_back('{1'b0, g, g, r, chk, o, t + 8});
        step(1);
        check("a_grant_at_launch", 32'(grant_a), 32'(g));
        check("a_busy_at_launch", 32'(busy_a), 32'd1);
        req_a = 4'b0;
        step(9);
    endtask

    // Watchdog DUT: error always lands at t+5.
    task automatic run_b(input logic [3:0] req, input logic [3:0] g);
        int t;
        t = cyc;
        req_b = req;
        exp_b.push_back('{1'b1, 4'b0, g, 8'h00, 1'b1, 1'b0, t + 5});
        step(1);
        check("b_grant_at_launch", 32'(grant_b), 32'(g));
        req_b = 4'b0;
        step(5);
    endtask

    task automatic check_a_idle_zero(input string tag);
        check({tag, "_grant"}, 32'(grant_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_error"}, 32'(err_a), 32'd0);
        check({tag, "_result"}, 32'(res_a), 32'd0);
        check({tag, "_overflow"}, 32'(ovf_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        int t;
        vectors = 0;
        miscompares = 0;
        rstn = 1'b0;
        req_a = '0; req_b = '0;
        vals_a = '0; vals_b = '0;
        bias_a = '0; bias_b = '0;
        step(3);
        check_a_idle_zero("reset_a");
        check("reset_b_busy", 32'(busy_b), 32'd0);
        check("reset_b_grant", 32'(grant_b), 32'd0);
        rstn = 1'b1;
        step(1);

        // All four held: grants 0,1,2,3,0, a DONE every 9 cycles.
        for (int r = 0; r < 4; r++) set_vals_a(r, 8'h08, 8'h00);
        t = cyc;
        req_a = 4'b1111;
        exp_a.push_back('{1'b0, 4'b0001, 4'b0001, 8'h20, 1'b1, 1'b0, t + 8});
        exp_a.push_back('{1'b0, 4'b0010, 4'b0010, 8'h20, 1'b1, 1'b0, t + 17});
        exp_a.push_back('{1'b0, 4'b0100, 4'b0100, 8'h20, 1'b1, 1'b0, t + 26});
        exp_a.push_back('{1'b0, 4'b1000, 4'b1000, 8'h20, 1'b1, 1'b0, t + 35});
        exp_a.push_back('{1'b0, 4'b0001, 4'b0001, 8'h20, 1'b1, 1'b0, t + 44});
        step(38);
        req_a = 4'b0;
        step(8);

        set_vals_a(0, 8'h04, 8'h00);
        run_a(4'b0001, 4'b0001, 8'h10, 1'b1, 1'b0);

        set_vals_a(2, 8'h7F, 8'h00);
        run_a(4'b0100, 4'b0100, 8'h7F, 1'b0, 1'b1);
        set_vals_a(0, 8'h01, 8'h00);
        run_a(4'b0001, 4'b0001, 8'h04, 1'b1, 1'b0);

        set_vals_a(1, 8'h08, 8'hF8);
        run_a(4'b0010, 4'b0010, 8'h18, 1'b1, 1'b0);

        // Reset while requester 1 is in WAIT; ptr was 2 beforehand.
        set_vals_a(1, 8'h08, 8'h00);
        set_vals_a(3, 8'h03, 8'h05);
        req_a = 4'b0010;
        step(4);
        check("a_busy_before_reset", 32'(busy_a), 32'd1);
        rstn = 1'b0;
        step(1);
        check_a_idle_zero("midreset_a");
        step(1);
        t = cyc;
        rstn = 1'b1;
        req_a = 4'b1010;
        exp_a.push_back('{1'b0, 4'b0010, 4'b0010, 8'h20, 1'b1, 1'b0, t + 8});
        exp_a.push_back('{1'b0, 4'b1000, 4'b1000, 8'h11, 1'b1, 1'b0, t + 17});
        step(11);
        req_a = 4'b0;
        step(9);

        for (int r = 0; r < 4; r++) for (int i = 0; i < 4; i++) vals_b[(r*4+i)*8 +: 8] = 8'h05;
        run_b(4'b0001, 4'b0001);
        run_b(4'b0010, 4'b0010);
        step(8);
        check("b_result_unchanged", 32'(res_b), 32'd0);
        check("b_idle_after_errors", 32'(busy_b), 32'd0);

        for (int i = 0; i < 200 && (exp_a.size() != 0 || exp_b.size() != 0); i++) step(1);
        check("a_pending_events", 32'(exp_a.size()), 32'd0);
        check("b_pending_events", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
